// File: rtl/shift_seq.sv
// shift_seq: command sequencer for a universal shift register (one load, up to N shifts, then hold + done).
// Optional rotate mode (cmd_rot port + shadow register) is built when SHIFT_SEQ_ROTATE_EN is defined.
module shift_seq #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [N-1:0]  cmd_data,
  input  logic          cmd_dir,
  input  logic [CW-1:0] cmd_count,
  input  logic          cmd_fill,
`ifdef SHIFT_SEQ_ROTATE_EN
  input  logic          cmd_rot,
`endif
  output logic [1:0]    s,
  output logic [N-1:0]  a,
  output logic          shift_in,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] MODE_LOAD  = 2'd0;
  localparam logic [1:0] MODE_RIGHT = 2'd1;
  localparam logic [1:0] MODE_LEFT  = 2'd2;
  localparam logic [1:0] MODE_HOLD  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic dir;
    logic fill;
`ifdef SHIFT_SEQ_ROTATE_EN
    logic rot;
`endif
  } cmd_t;

  state_e        state_q, state_d;
  cmd_t          cmd_q, cmd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_clamp;
  logic [1:0]    s_q, s_d;
  logic [N-1:0]  a_q, a_d;
  logic          shift_in_q, shift_in_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ready_q, ready_d;
  logic [1:0]    shift_mode;
  logic          serial_d;

  assign cnt_clamp  = (cmd_count > CW'(N)) ? CW'(N) : cmd_count;
  assign shift_mode = cmd_q.dir ? MODE_LEFT : MODE_RIGHT;

`ifdef SHIFT_SEQ_ROTATE_EN
  // Shadow mirrors the downstream register as it will be after the current cycle's edge.
  logic [N-1:0] shadow_q, shadow_d;

  always_comb begin
    shadow_d = shadow_q;
    if (state_q == ST_LOAD) begin
      shadow_d = a_q;
    end else if (state_q == ST_SHIFT) begin
      shadow_d = cmd_q.dir ? {shadow_q[N-2:0], shift_in_q}
                           : {shift_in_q, shadow_q[N-1:1]};
    end
  end

  assign serial_d = cmd_q.rot ? (cmd_q.dir ? shadow_d[N-1] : shadow_d[0]) : cmd_q.fill;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end
`else
  assign serial_d = cmd_q.fill;
`endif

  // Next-state and next-output logic; outputs are registered copies for the coming state.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    cnt_d      = cnt_q;
    s_d        = MODE_HOLD;
    a_d        = a_q;
    shift_in_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    ready_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (cmd_valid && ready_q) begin
          cmd_d.dir  = cmd_dir;
          cmd_d.fill = cmd_fill;
`ifdef SHIFT_SEQ_ROTATE_EN
          cmd_d.rot  = cmd_rot;
`endif
          cnt_d   = cnt_clamp;
          a_d     = cmd_data;
          s_d     = MODE_LOAD;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        busy_d = 1'b1;
        if (cnt_q != '0) begin
          s_d        = shift_mode;
          shift_in_d = serial_d;
          state_d    = ST_SHIFT;
        end else begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_SHIFT: begin
        busy_d = 1'b1;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          s_d        = shift_mode;
          shift_in_d = serial_d;
        end
      end

      ST_DONE: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      cnt_q      <= '0;
      s_q        <= MODE_HOLD;
      a_q        <= '0;
      shift_in_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      cnt_q      <= cnt_d;
      s_q        <= s_d;
      a_q        <= a_d;
      shift_in_q <= shift_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  assign cmd_ready = ready_q;
  assign s         = s_q;
  assign a         = a_q;
  assign shift_in  = shift_in_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_shift_seq.sv
// Testbench for shift_seq: per-cycle scoreboard of sequencer outputs plus a model of the downstream register.
module tb_shift_seq;
  localparam int unsigned N  = 8;
  localparam int unsigned CW = $clog2(N + 1);
`ifdef SHIFT_SEQ_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [N-1:0]  cmd_data = '0;
  logic          cmd_dir = 1'b0;
  logic [CW-1:0] cmd_count = '0;
  logic          cmd_fill = 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
  logic          cmd_rot = 1'b0;
`endif
  logic [1:0]    s;
  logic [N-1:0]  a;
  logic          shift_in;
  logic          busy;
  logic          done;

  typedef struct packed {
    logic [1:0]   s;
    logic [N-1:0] a;
    logic         si;
    logic         busy;
    logic         done;
    logic         rdy;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  logic [N-1:0] reg_m = '0;

  shift_seq #(.N(N), .CW(CW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_dir   (cmd_dir),
    .cmd_count (cmd_count),
    .cmd_fill  (cmd_fill),
`ifdef SHIFT_SEQ_ROTATE_EN
    .cmd_rot   (cmd_rot),
`endif
    .s         (s),
    .a         (a),
    .shift_in  (shift_in),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream universal shift register driven by the sequencer outputs.
  always @(posedge clk) begin
    case (s)
      2'd0:    reg_m <= a;
      2'd1:    reg_m <= {shift_in, reg_m[N-1:1]};
      2'd2:    reg_m <= {reg_m[N-2:0], shift_in};
      default: reg_m <= reg_m;
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.s    = s;
    o.a    = a;
    o.si   = shift_in;
    o.busy = busy;
    o.done = done;
    o.rdy  = cmd_ready;
    return o;
  endfunction

  function automatic obs_t mk(input logic [1:0] ms, input logic [N-1:0] ma, input logic msi,
                              input logic mb, input logic md, input logic mr);
    obs_t o;
    o.s = ms; o.a = ma; o.si = msi; o.busy = mb; o.done = md; o.rdy = mr;
    return o;
  endfunction

  // Waits for ready, presents one command for one edge and queues the expected output trace.
  task automatic issue(input logic [N-1:0] d, input logic dir, input logic [CW-1:0] cnt,
                       input logic fill, input logic rot);
    int w = 0;
    int ec;
    logic [N-1:0] v;
    logic bit_o;
    while (cmd_ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    n_checks++;
    if (cmd_ready !== 1'b1) $display("FAIL issue_ready: cmd_ready=%b want 1", cmd_ready);
    else n_pass++;

    cmd_data  = d;
    cmd_dir   = dir;
    cmd_count = cnt;
    cmd_fill  = fill;
`ifdef SHIFT_SEQ_ROTATE_EN
    cmd_rot   = rot;
`endif
    cmd_valid = 1'b1;

    ec = (int'(cnt) > int'(N)) ? int'(N) : int'(cnt);
    v  = d;
    exp_q.push_back(mk(2'd0, d, 1'b0, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < ec; i++) begin
      if (ROT_EN && rot) begin
        if (dir == 1'b0) begin
          bit_o = v[0];
          v = {v[0], v[N-1:1]};
        end else begin
          bit_o = v[N-1];
          v = {v[N-2:0], v[N-1]};
        end
      end else begin
        bit_o = fill;
      end
      exp_q.push_back(mk(dir ? 2'd2 : 2'd1, d, bit_o, 1'b1, 1'b0, 1'b0));
    end
    exp_q.push_back(mk(2'd3, d, 1'b0, 1'b1, 1'b1, 1'b0));
    exp_q.push_back(mk(2'd3, d, 1'b0, 1'b0, 1'b0, 1'b1));

    tick();
    cmd_valid = 1'b0;
  endtask

  // Pops one expected entry per cycle and compares against the sampled outputs.
  task automatic run_sb(input string name);
    obs_t e, o;
    int g = 0;
    while (exp_q.size() > 0 && g < 100) begin
      e = exp_q.pop_front();
      o = observe();
      n_checks++;
      if (o !== e)
        $display("FAIL %s cyc=%0d got s=%0d a=%h si=%b busy=%b done=%b rdy=%b want s=%0d a=%h si=%b busy=%b done=%b rdy=%b",
                 name, cyc, o.s, o.a, o.si, o.busy, o.done, o.rdy,
                 e.s, e.a, e.si, e.busy, e.done, e.rdy);
      else n_pass++;
      if (exp_q.size() > 0) tick();
      g++;
    end
  endtask

  task automatic check_reg(input string name, input logic [N-1:0] want);
    n_checks++;
    if (reg_m !== want) $display("FAIL %s: register=%h want %h", name, reg_m, want);
    else n_pass++;
  endtask

  task automatic test_reset();
    obs_t o;
    #2 reset_n = 1'b0;
    #1;
    o = observe();
    n_checks++;
    if (o !== mk(2'd3, '0, 1'b0, 1'b0, 1'b0, 1'b1))
      $display("FAIL reset_values: s=%0d a=%h si=%b busy=%b done=%b rdy=%b want 3/00/0/0/0/1",
               o.s, o.a, o.si, o.busy, o.done, o.rdy);
    else n_pass++;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) exp_q.push_back(mk(2'd3, '0, 1'b0, 1'b0, 1'b0, 1'b1));
    run_sb("idle");
  endtask

  task automatic test_shift_right();
    issue(8'hA5, 1'b0, CW'(3), 1'b1, 1'b0);
    // Commands offered while busy must be ignored.
    cmd_data  = 8'hFF;
    cmd_count = CW'(1);
    cmd_valid = 1'b1;
    run_sb("right3");
    cmd_valid = 1'b0;
    check_reg("right3_reg", 8'hF4);
  endtask

  task automatic test_count_zero();
    issue(8'h81, 1'b1, CW'(0), 1'b0, 1'b0);
    run_sb("cnt0");
    check_reg("cnt0_reg", 8'h81);
  endtask

  task automatic test_shift_left();
    issue(8'h0F, 1'b1, CW'(2), 1'b1, 1'b0);
    run_sb("left2");
    check_reg("left2_reg", 8'h3F);
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int shifts = 0;
    int g = 0;
    cmd_data  = 8'h3C;
    cmd_dir   = 1'b1;
    cmd_count = CW'(15);
    cmd_fill  = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (cmd_ready === 1'b1) acc.push_back(i);
      if ((s == 2'd1 || s == 2'd2) && acc.size() == 1) shifts++;
      tick();
    end
    cmd_valid = 1'b0;
    n_checks++;
    if (acc.size() < 3) $display("FAIL b2b_accepts: got %0d accepts want 3", acc.size());
    else n_pass++;
    if (acc.size() >= 3) begin
      n_checks++;
      if (acc[1] - acc[0] !== 11) $display("FAIL b2b_gap1: got %0d want 11", acc[1] - acc[0]);
      else n_pass++;
      n_checks++;
      if (acc[2] - acc[1] !== 11) $display("FAIL b2b_gap2: got %0d want 11", acc[2] - acc[1]);
      else n_pass++;
    end
    n_checks++;
    if (shifts !== 8) $display("FAIL clamp_shifts: got %0d want 8", shifts);
    else n_pass++;
    while (done !== 1'b1 && g < 30) begin
      tick();
      g++;
    end
    n_checks++;
    if (done !== 1'b1) $display("FAIL b2b_done: done=%b want 1", done);
    else n_pass++;
    tick();
    n_checks++;
    if (cmd_ready !== 1'b1) $display("FAIL b2b_ready: cmd_ready=%b want 1", cmd_ready);
    else n_pass++;
    check_reg("clamp_reg", 8'h00);
  endtask

  task automatic test_reset_mid();
    obs_t o;
    logic seen_done = 1'b0;
    issue(8'hA5, 1'b0, CW'(3), 1'b1, 1'b0);
    exp_q.delete();
    tick();
    tick();
    n_checks++;
    if (s !== 2'd1) $display("FAIL mid_shift2: s=%0d want 1", s);
    else n_pass++;
    reset_n = 1'b0;
    #1;
    o = observe();
    n_checks++;
    if (o !== mk(2'd3, '0, 1'b0, 1'b0, 1'b0, 1'b1))
      $display("FAIL mid_reset_values: s=%0d a=%h si=%b busy=%b done=%b rdy=%b want 3/00/0/0/0/1",
               o.s, o.a, o.si, o.busy, o.done, o.rdy);
    else n_pass++;
    repeat (2) begin
      tick();
      if (done === 1'b1) seen_done = 1'b1;
    end
    reset_n = 1'b1;
    repeat (4) begin
      tick();
      if (done === 1'b1) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done !== 1'b0) $display("FAIL mid_no_done: done pulse seen=%b want 0", seen_done);
    else n_pass++;
    n_checks++;
    if (cmd_ready !== 1'b1 || s !== 2'd3 || busy !== 1'b0)
      $display("FAIL mid_after_release: rdy=%b s=%0d busy=%b want 1/3/0", cmd_ready, s, busy);
    else n_pass++;
  endtask

  task automatic test_rotate();
    issue(8'h01, 1'b0, CW'(1), 1'b0, 1'b1);
    run_sb("rot_right1");
    check_reg("rot_right1_reg", 8'h80);
    issue(8'h01, 1'b1, CW'(8), 1'b0, 1'b1);
    run_sb("rot_left8");
    check_reg("rot_left8_reg", 8'h01);
    issue(8'hB4, 1'b0, CW'(3), 1'b0, 1'b1);
    run_sb("rot_right3");
    check_reg("rot_right3_reg", 8'h96);
  endtask

  initial begin
    test_reset();
    test_shift_right();
    test_count_zero();
    test_shift_left();
    test_back_to_back();
    test_reset_mid();
    if (ROT_EN) test_rotate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
